// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and flag bundle shared by the execute-stage ALU
package alu_pkg;
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_CMP  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SAR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_PASS = 4'd9;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    typedef struct packed {
        logic zf;
        logic cf;
        logic nf;
        logic vf;
    } flags_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CW = $clog2(WIDTH);

    logic               busy;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, mc;
    logic [WIDTH-1:0]   mp;

    // prod is the accumulator after the current step, so it is final while done is high
    assign prod = acc + (mp[0] ? mc : '0);
    assign done = busy && (cnt == CW'(WIDTH - 1));

    // load operands on start, then shift multiplicand left and multiplier right each step
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            mc   <= '0;
            mp   <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            acc  <= '0;
            mc   <= {{WIDTH{1'b0}}, a};
            mp   <= b;
        end else if (busy) begin
            acc  <= prod;
            mc   <= mc << 1;
            mp   <= mp >> 1;
            cnt  <= cnt + 1'b1;
            busy <= !done;
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered execute-stage ALU with flags, shifts and iterative multiply
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [OPW-1:0]   op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zf,
    output logic             cf,
    output logic             nf,
    output logic             vf,
    output logic             err
);
    state_t             st, st_n;
    flags_t             fl, fl_n;
    logic               accept, retire, is_mul, mdone;
    logic               c, v, bad_op;
    logic [WIDTH-1:0]   res, fin;
    logic [WIDTH:0]     sum, dif, shl_w, shr_w, sar_w;
    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] prod;

    assign sh       = in0[SHW-1:0];
    assign is_mul   = op == OPW'(OP_MUL);
    assign in_ready = (st != MUL) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid && out_ready;
    assign sum      = {1'b0, in0} + {1'b0, in1};
    assign dif      = {1'b0, in1} - {1'b0, in0};
    assign shl_w    = {1'b0, in1} << sh;
    assign shr_w    = {in1, 1'b0} >> sh;
    assign sar_w    = $signed({in1, 1'b0}) >>> sh;
    assign {zf, cf, nf, vf} = fl;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .start(accept && is_mul),
        .a    (in0),
        .b    (in1),
        .done (mdone),
        .prod (prod)
    );

    // single-cycle result and raw carry/overflow for every non-MUL opcode
    always_comb begin
        res    = '0;
        c      = 1'b0;
        v      = 1'b0;
        bad_op = 1'b0;
        case (op)
            OPW'(OP_AND):  res = in0 & in1;
            OPW'(OP_OR):   res = in0 | in1;
            OPW'(OP_ADD):  begin
                {c, res} = sum;
                v = (in0[WIDTH-1] == in1[WIDTH-1]) && (sum[WIDTH-1] != in0[WIDTH-1]);
            end
            OPW'(OP_SUB):  begin
                {c, res} = dif;
                v = (in0[WIDTH-1] != in1[WIDTH-1]) && (dif[WIDTH-1] != in1[WIDTH-1]);
            end
            OPW'(OP_CMP):  res = {{(WIDTH-1){1'b0}}, in0 == in1};
            OPW'(OP_SHL):  {c, res} = shl_w;
            OPW'(OP_SHR):  {res, c} = shr_w;
            OPW'(OP_SAR):  {res, c} = sar_w;
            OPW'(OP_MUL):  res = '0;
            OPW'(OP_PASS): res = in0;
            default:       bad_op = 1'b1;
        endcase
    end

    // the multiplier owns the result while in MUL; otherwise the single-cycle path does
    always_comb begin
        fin  = (st == MUL) ? prod[WIDTH-1:0] : res;
        fl_n = '{zf: fin == '0,
                 cf: (st == MUL) ? |prod[2*WIDTH-1:WIDTH] : c,
                 nf: fin[WIDTH-1],
                 vf: (st == MUL) ? 1'b0 : v};
    end

    // accept takes priority so DONE can retire and start the next op in one edge
    always_comb begin
        st_n = st;
        if (accept)
            st_n = is_mul ? MUL : IDLE;
        else if (mdone)
            st_n = DONE;
        else if (st == DONE && retire)
            st_n = IDLE;
    end

    // state, output register and handshake bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            fl        <= '{zf: 1'b1, cf: 1'b0, nf: 1'b0, vf: 1'b0};
            err       <= 1'b0;
        end else begin
            st <= st_n;
            if (accept)
                out_valid <= !is_mul;
            else if (mdone)
                out_valid <= 1'b1;
            else if (retire)
                out_valid <= 1'b0;
            if ((accept && !is_mul) || mdone) begin
                out <= fin;
                fl  <= fl_n;
                err <= (st == MUL) ? 1'b0 : bad_op;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed checks of alu_pipe at WIDTH=8
module tb_alu_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in0 = '0;
    logic [7:0] in1 = '0;
    logic [3:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out;
    logic       zf, cf, nf, vf, err;
    int         total = 0;
    int         bad = 0;

    alu_pipe #(.WIDTH(8), .OPW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zf(zf), .cf(cf), .nf(nf), .vf(vf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        op = o; in0 = a; in1 = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({out_valid, out, zf, cf, nf, vf, err, in_ready} !== {1'b0, 8'h00, 1'b1, 4'b0000, 1'b1}) begin
            bad++;
            $display("FAIL reset: got v=%b out=%h zcnv=%b%b%b%b err=%b rdy=%b want v=0 out=00 zcnv=1000 err=0 rdy=1",
                     out_valid, out, zf, cf, nf, vf, err, in_ready);
        end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        issue(4'd2, 8'hFF, 8'h01);
        total++;
        if ({out_valid, out, zf, cf, nf, vf} !== {1'b1, 8'h00, 4'b1100}) begin
            bad++;
            $display("FAIL add_carry: got v=%b out=%h zcnv=%b%b%b%b want v=1 out=00 zcnv=1100",
                     out_valid, out, zf, cf, nf, vf);
        end
    endtask

    task automatic test_sub();
        issue(4'd3, 8'h01, 8'h80);
        total++;
        if ({out, zf, cf, nf, vf} !== {8'h7F, 4'b0001}) begin
            bad++;
            $display("FAIL sub_ovf: got out=%h zcnv=%b%b%b%b want out=7f zcnv=0001", out, zf, cf, nf, vf);
        end
        issue(4'd3, 8'h01, 8'h00);
        total++;
        if ({out, zf, cf, nf, vf} !== {8'hFF, 4'b0110}) begin
            bad++;
            $display("FAIL sub_borrow: got out=%h zcnv=%b%b%b%b want out=ff zcnv=0110", out, zf, cf, nf, vf);
        end
    endtask

    task automatic test_mul_case(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] exp, input logic expc);
        int n = 0;
        logic stall_ok = 1'b1;
        issue(4'd8, a, b);
        op = 4'd2; in0 = 8'h01; in1 = 8'h01; in_valid = 1'b1;
        while (!out_valid && n < 20) begin
            if (in_ready !== 1'b0) stall_ok = 1'b0;
            tick();
            n++;
        end
        in_valid = 1'b0;
        total++;
        if (n != 8 || !stall_ok) begin
            bad++;
            $display("FAIL mul_latency: got %0d busy cycles stall_ok=%b want 8 and 1", n, stall_ok);
        end
        total++;
        if ({out_valid, out, cf, vf, err} !== {1'b1, exp, expc, 2'b00}) begin
            bad++;
            $display("FAIL mul_result: got v=%b out=%h cf=%b vf=%b err=%b want v=1 out=%h cf=%b vf=0 err=0",
                     out_valid, out, cf, vf, err, exp, expc);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [6] = '{4'd2, 4'd1, 4'd5, 4'd6, 4'd7, 4'd4};
        logic [7:0] as  [6] = '{8'h02, 8'hF0, 8'h09, 8'h0A, 8'h03, 8'h05};
        logic [7:0] bs  [6] = '{8'h03, 8'h0F, 8'h81, 8'h86, 8'h84, 8'h05};
        logic [7:0] es  [6] = '{8'h05, 8'hFF, 8'h02, 8'h21, 8'hF0, 8'h01};
        logic [1:0] fs  [6] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op = ops[i]; in0 = as[i]; in1 = bs[i];
            tick();
            total++;
            if ({out_valid, in_ready, out, cf, nf} !== {2'b11, es[i], fs[i]}) begin
                bad++;
                $display("FAIL b2b_%0d: got v=%b rdy=%b out=%h cf=%b nf=%b want v=1 rdy=1 out=%h cf=%b nf=%b",
                         i, out_valid, in_ready, out, cf, nf, es[i], fs[i][1], fs[i][0]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        logic held = 1'b1;
        out_ready = 1'b0;
        issue(4'd2, 8'h03, 8'h04);
        op = 4'd9; in0 = 8'h5A; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if ({out_valid, out, in_ready} !== {1'b1, 8'h07, 1'b0}) held = 1'b0;
            tick();
        end
        total++;
        if (!held || out !== 8'h07) begin
            bad++;
            $display("FAIL stall_hold: got out=%h held=%b want out=07 held=1", out, held);
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if ({out_valid, out} !== {1'b1, 8'h5A}) begin
            bad++;
            $display("FAIL stall_replace: got v=%b out=%h want v=1 out=5a", out_valid, out);
        end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        logic quiet = 1'b1;
        issue(4'd8, 8'h10, 8'h11);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({out_valid, out, zf, in_ready} !== {1'b0, 8'h00, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL rst_mid_mul: got v=%b out=%h zf=%b rdy=%b want v=0 out=00 zf=1 rdy=1",
                     out_valid, out, zf, in_ready);
        end
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0) quiet = 1'b0;
            tick();
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL rst_stale_result: a result appeared after reset, want none");
        end
        issue(4'hC, 8'h12, 8'h34);
        total++;
        if ({out_valid, out, err, zf} !== {1'b1, 8'h00, 2'b11}) begin
            bad++;
            $display("FAIL bad_opcode: got v=%b out=%h err=%b zf=%b want v=1 out=00 err=1 zf=1",
                     out_valid, out, err, zf);
        end
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_add();
        test_sub();
        test_mul_case(8'h10, 8'h11, 8'h10, 1'b1);
        test_mul_case(8'h0F, 8'h03, 8'h2D, 1'b0);
        test_back_to_back();
        test_stall();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the 8-bit combinational CPU ALU.
- Datapath width is generic. Adds carry, negative and overflow flags, shifts, and an iterative multiply.
- Operands and results move through valid/ready handshakes, so the CPU core can stall on MUL or on a busy writeback.
- Sits between register-file read and writeback in the execute stage.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4, power of two).
- OPW, 4, opcode width.
- SHW, $clog2(WIDTH), shift-amount width taken from in0[SHW-1:0].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op present.
- in_ready  out  1  block accepts operands this cycle.
- in0  in  WIDTH  operand A (immediate/offset side).
- in1  in  WIDTH  operand B (register side).
- op  in  OPW  operation code.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- zf  out  1  zero flag.
- cf  out  1  carry/borrow/multiply-overflow flag.
- nf  out  1  result MSB.
- vf  out  1  signed overflow.
- err  out  1  unsupported opcode.

Behaviour:
- Reset: state=IDLE, out_valid=0, out=0, zf=1, cf=nf=vf=err=0. Applies on any cycle, including mid-MUL; a partial product is discarded and no result is emitted.
- Handshakes:
  - Accept when in_valid&&in_ready.
  - Result retires when out_valid&&out_ready.
  - in_ready = (state!=MUL) && (!out_valid || out_ready).
  - When a retire and an accept coincide, the new result replaces the old one on the next edge. Throughput is 1 op/cycle for non-MUL ops.
  - out, flags and out_valid hold stable while out_valid&&!out_ready.
- Opcodes (op value: function):
  - 0 AND: in0&in1.
  - 1 OR: in0|in1.
  - 2 ADD: in0+in1.
  - 3 SUB: in1-in0.
  - 4 CMP: out = (in0==in1) zero-extended.
  - 5 SHL: in1<<sh.
  - 6 SHR: logical in1>>sh.
  - 7 SAR: arithmetic in1>>>sh.
  - 8 MUL: low WIDTH bits of in0*in1, unsigned.
  - 9 PASS: in0.
  - 10-15: out=0, err=1.
- Latency: all non-MUL ops take 1 cycle (out_valid rises on the edge after accept). MUL takes WIDTH+1 cycles.
- FSM:
  - IDLE: on accept of MUL, load multiplicand/multiplier, clear the 2*WIDTH-bit accumulator and counter, then go to MUL.
  - MUL: one shift-add step per cycle. When counter==WIDTH-1, go to DONE.
  - DONE: drive the result and out_valid=1 on entry. Go to IDLE when the result retires; if a retire and an accept coincide, follow the IDLE accept rule in the same edge.
  - Non-MUL ops never leave IDLE.
- Flags, computed on the final WIDTH-bit result:
  - zf = (out==0).
  - nf = out[WIDTH-1].
  - ADD: cf = carry out; vf = signed overflow of in0+in1.
  - SUB: cf = borrow (in0>in1 unsigned); vf = signed overflow of in1-in0.
  - SHL: cf = last bit shifted out. SHR/SAR: cf = last bit shifted out. cf=0 if sh==0.
  - MUL: cf = |product[2*WIDTH-1:WIDTH]; vf=0.
  - All other ops: cf=vf=0.
- Boundaries:
  - Shift amount is in0[SHW-1:0]; upper bits are ignored.
  - MUL by 0 still takes WIDTH+1 cycles.
  - in_valid while in MUL is ignored (in_ready=0), and inputs need not be held stable.

Decomposition:
- Package alu_pkg: opcode localparams (AND..PASS), the FSM state encoding (IDLE, MUL, DONE), and a flag-bundle typedef {zf,cf,nf,vf}. Shared with decoder and branch logic.
- One sub-module, alu_mul_iter: shift-add multiplier with start/done signals and a WIDTH-cycle count, instantiated once.

Test Plan (WIDTH=8):
- ADD in0=0xFF, in1=0x01, out_ready=1 -> next cycle out=0x00, zf=1, cf=1, vf=0, nf=0.
- SUB in0=0x01, in1=0x80 -> out=0x7F, vf=1, cf=0, nf=0. Then SUB in0=0x01, in1=0x00 -> out=0xFF, cf=1, nf=1.
- MUL in0=0x10, in1=0x11 -> in_ready=0 for 8 cycles; out_valid after 9 cycles; out=0x10, cf=1. MUL 0x0F*0x03 -> 0x2D, cf=0.
- Back-to-back ADD/OR/SHL(in0=0x09 -> sh=1, in1=0x81) with out_ready=1 -> one result per cycle. SHL result=0x02, cf=1.
- Hold out_ready=0 after ADD 3+4 -> out=0x07 held, in_ready=0. Release -> retire and accept the next op in the same cycle.
- Assert rst 4 cycles into MUL -> next cycle state IDLE, out_valid=0, zf=1, in_ready=1, and no stale result emitted. op=0xC -> out=0, err=1, zf=1.
